grid_update_scheduler: RTL
==========================

Name: grid_update_scheduler

Overview:
- Schedules all writes into the snake grid register that feeds the VGA display, so the grid only changes during vertical blanking (no tearing).
- Divides frames into game ticks and opens a bounded write window once per tick.
- Arbitrates that window between two requesters: requester 0 is the snake mover; requester 1 is the food placer.
- Arbitration is round-robin at burst boundaries; the block drives a single registered grid write port.

Parameters:
- GRID_CELLS, 192, number of grid cells (16 x 12).
- IDX_W, 8, cell index width; must satisfy 2^IDX_W >= GRID_CELLS.
- TICK_FRAMES, 6, frames per game tick; must be >= 1.
- WINDOW_CYCLES, 8000, maximum clock cycles in the write window per tick; must be >= 1.

Ports:
- Clock  in  1  pixel clock, rising edge.
- Reset  in  1  synchronous, active-high.
- FrameStart  in  1  one-cycle pulse when the display enters vertical blanking.
- Req  in  2  per-requester request; held until granted.
- Last  in  2  per-requester flag: current beat is the final beat of its burst.
- Index0, Index1  in  IDX_W each  cell index for requester 0 / 1.
- Data0, Data1  in  2 each  block code (EMPTY / SNAKE / FOOD / WALL) for requester 0 / 1.
- Grant  out  2  combinational one-hot grant; a beat is accepted when Req & Grant.
- Tick  out  1  one-cycle pulse when a tick's window opens.
- WindowOpen  out  1  high while the write window is open.
- WrEn  out  1  registered grid write enable.
- WrIndex  out  IDX_W  registered write cell index.
- WrData  out  2  registered write block code.
- Overrun  out  1  sticky error flag.

Behaviour:
- Reset: state IDLE; frame count = 0; window count = 0; owner = none; last-owner pointer = 1 (so requester 0 wins first). Done bits = 00. Outputs Grant = 00, Tick = 0, WindowOpen = 0, WrEn = 0, WrIndex = 0, WrData = 0, Overrun = 0.
- Frame counting runs in every state:
  - Each FrameStart increments the frame count, wrapping to 0 at TICK_FRAMES-1.
  - A wrap is a "tick due".
- IDLE:
  - Tick due -> TICK.
- TICK (exactly 1 cycle):
  - Tick = 1; window count loaded with WINDOW_CYCLES-1; Done bits cleared.
  - Next state ARB.
- ARB:
  - WindowOpen = 1.
  - No owner: grant the requester with Req=1 and Done=0, preferring the requester that is not the last-owner pointer. That requester becomes owner and the pointer is updated. The grant is given in the same cycle.
  - Owner set: Grant holds on the owner only. Cycles where the owner has Req=0 are idle beats; grant is not passed to the other requester.
  - Accepted beat: in the next cycle WrEn = 1 and WrIndex/WrData equal the captured Index/Data (1-cycle latency). Otherwise WrEn = 0.
  - Accepted beat with Last = 1: owner's Done bit set, owner cleared. Re-arbitration occurs the following cycle.
  - Index >= GRID_CELLS on an accepted beat: beat is consumed but WrEn stays 0 (write dropped).
  - Window count decrements every ARB cycle.
  - Exit to IDLE when both Done bits are set.
  - Exit to IDLE when the window count reaches 0 and the final cycle has completed. Grant drops to 00 on exit.
  - If this exit occurs with an owner mid-burst, or any Req=1 with Done=0: Overrun is set and the remaining beats are lost. The requester must restart on the next tick.
- Tick due while not in IDLE: tick is skipped, Overrun is set, and the frame count still wraps.
- FrameStart coincident with TICK or the ARB exit cycle: it is counted normally.
- Overrun is cleared only by Reset.
- Reset asserted in any state: returns to reset values on the next edge. A pending registered write is squashed (WrEn = 0).
- Width rules: frame counter is clog2(TICK_FRAMES) bits, minimum 1; window counter is clog2(WINDOW_CYCLES) bits, minimum 1. All compares are unsigned.

Optional Feature:
- Macro: SCHED_PAUSE_EN.
- When defined:
  - Adds input Pause (1 bit), placed after FrameStart.
  - While Pause = 1: FrameStart is ignored (frame count frozen) and no tick becomes due.
  - A window already in ARB runs to completion.
- When undefined: no Pause port; frame counting is never frozen.

Test Plan:
- Bench parameters for all scenarios: TICK_FRAMES=4, WINDOW_CYCLES=16.
- Reset, then 4 FrameStart pulses -> exactly one Tick on the cycle after the 4th pulse; WindowOpen=1 the cycle after Tick. The first 3 pulses produce no Tick.
- Both Req=1 at window open; req0 bursts 3 beats (idx 5,6,7; Last on 7); req1 bursts 1 beat (idx 40, FOOD):
  - Expect Grant=01 for 3 beats, then 10.
  - WrEn pulses carry idx 5,6,7,40, each 1 cycle after acceptance.
  - Window closes after both Done bits are set; Overrun=0.
- req0 holds Req=1 and never asserts Last -> 16 ARB cycles, Grant drops to 00, WindowOpen=0, Overrun=1. Overrun stays 1 until Reset.
- Accepted beat with Index=200 -> no WrEn for that beat; the next beat (idx 3) writes normally.
- Reset asserted mid-burst, on the cycle after an accepted beat -> WrEn=0 next cycle and all outputs at reset values. After release, 4 FrameStart pulses are required for the next Tick.
- With SCHED_PAUSE_EN: Pause=1 during 8 FrameStart pulses -> no Tick. Then Pause=0 and 4 pulses -> Tick.

Source files
------------

// File: rtl/grid_update_scheduler.sv
// grid_update_scheduler: paces grid writes into vblank-aligned, tick-gated windows and arbitrates
// them round-robin per burst onto one registered write port. Optional Pause input: SCHED_PAUSE_EN.
module grid_update_scheduler #(
  parameter int GRID_CELLS    = 192,
  parameter int IDX_W         = 8,
  parameter int TICK_FRAMES   = 6,
  parameter int WINDOW_CYCLES = 8000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             frame_start_i,
`ifdef SCHED_PAUSE_EN
  input  logic             pause_i,
`endif
  input  logic [1:0]       req_i,
  input  logic [1:0]       last_i,
  input  logic [IDX_W-1:0] index0_i,
  input  logic [IDX_W-1:0] index1_i,
  input  logic [1:0]       data0_i,
  input  logic [1:0]       data1_i,
  output logic [1:0]       grant_o,
  output logic             tick_o,
  output logic             window_open_o,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_index_o,
  output logic [1:0]       wr_data_o,
  output logic             overrun_o
);

  localparam int FC_W = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
  localparam int WC_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int CW   = IDX_W + 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(TICK_FRAMES - 1);
  localparam logic [WC_W-1:0] WC_LOAD = WC_W'(WINDOW_CYCLES - 1);
  localparam logic [CW-1:0]   CELLS   = CW'(GRID_CELLS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TICK = 2'd1,
    S_ARB  = 2'd2
  } state_e;

  state_e           state_q;
  logic [FC_W-1:0]  frame_cnt_q;
  logic [WC_W-1:0]  win_cnt_q;
  logic [1:0]       done_q;
  logic             owner_vld_q;
  logic             owner_q;
  logic             ptr_q;
  logic             tick_q;
  logic             window_open_q;
  logic             wr_en_q;
  logic [IDX_W-1:0] wr_index_q;
  logic [1:0]       wr_data_q;
  logic             overrun_q;

  logic             frame_ev_s;
  logic             tick_due_s;
  logic [1:0]       elig_s;
  logic [1:0]       grant_s;
  logic             gsel_s;
  logic             accept_s;
  logic             fin_s;
  logic [IDX_W-1:0] sel_index_s;
  logic [1:0]       sel_data_s;
  logic             wr_fire_s;
  logic [1:0]       done_n_s;
  logic             owner_vld_n_s;
  logic             ptr_n_s;

  // Frame pacing and same-cycle window arbitration; the grant has to be combinational
  always_comb begin
`ifdef SCHED_PAUSE_EN
    frame_ev_s = frame_start_i & ~pause_i;
`else
    frame_ev_s = frame_start_i;
`endif
    tick_due_s = frame_ev_s && (frame_cnt_q == FC_LAST);
    elig_s     = req_i & ~done_q;
    if (state_q != S_ARB) begin
      grant_s = 2'b00;
    end else if (owner_vld_q) begin
      grant_s = owner_q ? 2'b10 : 2'b01;
    end else if (elig_s == 2'b11) begin
      grant_s = ptr_q ? 2'b01 : 2'b10;
    end else begin
      grant_s = elig_s;
    end
    gsel_s        = grant_s[1];
    accept_s      = |(req_i & grant_s);
    fin_s         = accept_s & last_i[gsel_s];
    sel_index_s   = gsel_s ? index1_i : index0_i;
    sel_data_s    = gsel_s ? data1_i : data0_i;
    // Out-of-range indices are consumed as beats but never reach the grid
    wr_fire_s     = accept_s && ({1'b0, sel_index_s} < CELLS);
    done_n_s      = fin_s ? (done_q | grant_s) : done_q;
    owner_vld_n_s = (|grant_s) && !fin_s;
    ptr_n_s       = (!owner_vld_q && (|grant_s)) ? gsel_s : ptr_q;
  end

  // Scheduler state machine, frame/window counters and registered write port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      frame_cnt_q   <= {FC_W{1'b0}};
      win_cnt_q     <= {WC_W{1'b0}};
      done_q        <= 2'b00;
      owner_vld_q   <= 1'b0;
      owner_q       <= 1'b0;
      ptr_q         <= 1'b1;
      tick_q        <= 1'b0;
      window_open_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_index_q    <= {IDX_W{1'b0}};
      wr_data_q     <= 2'b00;
      overrun_q     <= 1'b0;
    end else begin
      if (frame_ev_s) begin
        frame_cnt_q <= tick_due_s ? {FC_W{1'b0}} : frame_cnt_q + FC_W'(1);
      end
      if (tick_due_s && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      wr_en_q <= wr_fire_s;
      if (wr_fire_s) begin
        wr_index_q <= sel_index_s;
        wr_data_q  <= sel_data_s;
      end
      tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick_due_s) begin
            state_q <= S_TICK;
            tick_q  <= 1'b1;
          end
        end
        S_TICK: begin
          state_q       <= S_ARB;
          window_open_q <= 1'b1;
          win_cnt_q     <= WC_LOAD;
          done_q        <= 2'b00;
          owner_vld_q   <= 1'b0;
        end
        S_ARB: begin
          done_q    <= done_n_s;
          ptr_q     <= ptr_n_s;
          owner_q   <= gsel_s;
          win_cnt_q <= win_cnt_q - WC_W'(1);
          if (done_n_s == 2'b11) begin
            state_q       <= S_IDLE;
            window_open_q <= 1'b0;
            owner_vld_q   <= 1'b0;
          end else if (win_cnt_q == {WC_W{1'b0}}) begin
            state_q       <= S_IDLE;
            window_open_q <= 1'b0;
            owner_vld_q   <= 1'b0;
            if (owner_vld_n_s || (|(req_i & ~done_n_s))) begin
              overrun_q <= 1'b1;
            end
          end else begin
            owner_vld_q <= owner_vld_n_s;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          window_open_q <= 1'b0;
          owner_vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o       = grant_s;
  assign tick_o        = tick_q;
  assign window_open_o = window_open_q;
  assign wr_en_o       = wr_en_q;
  assign wr_index_o    = wr_index_q;
  assign wr_data_o     = wr_data_q;
  assign overrun_o     = overrun_q;

endmodule
